topk_fp32_collector: RTL and testbench
======================================

Name: topk_fp32_collector

Overview:
- Streaming top-K collector. Sits at the output end of the compare-swap sorting network.
- Accepts a stream of fp32 words and keeps the K largest-magnitude words in a sorted register bank, using a parallel compare plus one-cycle shift-insert.
- On the stream's last word it drains the K results through a valid/ready handshake.
- Ordering key matches the sorting network: {exp, frac} compared as unsigned; the sign bit is ignored for ordering but carried in the data.

Parameters:
- DATA_WIDTH, 32, word width (fp32 layout: sign[31], exp[30:23], frac[22:0]).
- K, 8, number of retained entries (2..32).
- DESCENDING, 1, drain order: 1 = largest first, 0 = smallest of the retained set first.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- i_valid  input  1  input word valid.
- i_ready  output  1  collector can accept an input word.
- i_data  input  DATA_WIDTH  input fp32 word.
- i_last  input  1  final word of the current stream; qualified by i_valid && i_ready.
- o_valid  output  1  output word valid.
- o_ready  input  1  downstream accepts the output word.
- o_data  output  DATA_WIDTH  drained word.
- o_last  output  1  final drained word.
- o_count  output  $clog2(K+1)  number of currently retained entries.

Behaviour:
- Reset (async, rst=0):
  - All slots = 0, count = 0, state = COLLECT, rd_idx = 0.
  - o_valid = 0, o_last = 0, o_data = 0, i_ready = 0 while rst is low.
- All outputs decode from registers only. There is no combinational path from i_* or o_ready to any output.
- Storage: slot[0..K-1] is always kept sorted by key, descending; slot[0] holds the largest. Only slots below count are meaningful.
- COLLECT state:
  - i_ready = 1 and o_valid = 0.
  - On accept (i_valid && i_ready), compute p = number of valid slots with key >= new key. Ties therefore insert after existing equal keys (stable order).
  - count < K: write the new word at slot p, shift slots p..count-1 down by one, count += 1.
  - count == K and p < K: insert at p, shift down, discard the old slot[K-1]; count stays K.
  - count == K and p == K: discard the new word; no state change.
  - Insertion completes in the accept cycle, so the collector sustains one word per cycle.
  - If the accepted word has i_last = 1: apply the insertion, then move to DRAIN next cycle. count >= 1 is guaranteed.
  - i_last without i_valid has no effect.
- DRAIN state:
  - i_ready = 0; i_valid is ignored.
  - o_valid = 1.
  - o_data = slot[rd_idx] when DESCENDING = 1; slot[count-1-rd_idx] when DESCENDING = 0.
  - o_last = 1 when rd_idx == count-1.
  - On o_valid && o_ready: rd_idx += 1.
  - On the handshake with o_last: clear count and rd_idx to 0, return to COLLECT; i_ready = 1 the following cycle. Slot contents need not be cleared.
  - With o_ready low, o_data and o_last hold stable and o_valid stays 1.
- Latency: from the accept of the i_last word to first o_valid is 1 cycle.
- Reset mid-operation (either state): abandon all data immediately; no partial output is emitted after rst deasserts.
- Special values:
  - NaN/Inf are ordered purely by {exp, frac}, so NaN > Inf.
  - +0 and -0 are equal keys.

Test Plan:
- K=4, DESCENDING=1: stream 0x3F800000, 0x40400000, 0x40000000, 0x3F000000, 0x40800000(last) -> drain 0x40800000, 0x40400000, 0x40000000, 0x3F800000 with o_last on the 4th; 0x3F000000 dropped; first o_valid 1 cycle after the last accept.
- Sign ignored plus stable ties: 0xC0A00000, 0x40000000, 0xC0000000(last) -> drain 0xC0A00000, 0x40000000, 0xC0000000.
- Backpressure: during the above drain, hold o_ready=0 for 3 cycles after the first word -> o_data holds 0x40000000, o_valid stays 1, i_ready stays 0; i_valid=1 with 0x7F000000 during DRAIN is ignored and absent from output.
- Single word: 0x3F800000 with i_last -> one beat, o_data=0x3F800000, o_last=1; i_ready=1 the next cycle; o_count=0.
- DESCENDING=0, K=4, same stream as the first test -> drain 0x3F800000, 0x40000000, 0x40400000, 0x40800000.
- Assert rst low mid-drain after 2 beats -> o_valid=0 and o_count=0 immediately; after release, a new stream 0x40000000(last) drains exactly one word.

Source files
------------

// File: rtl/topk_fp32_collector.sv
// topk_fp32_collector
//   Streaming top-K collector for fp32 words. Keeps the K largest-magnitude
//   words seen in a stream in a sorted register bank. The ordering key is
//   {exp, frac} compared as unsigned, and the sign is carried but not ranked.
//   When the word flagged i_last is accepted, the retained set is drained
//   through a valid/ready handshake.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-low reset
//   i_valid  in   input word valid
//   i_ready  out  collector can accept a word (COLLECT state, out of reset)
//   i_data   in   input fp32 word
//   i_last   in   final word of the stream, qualified by i_valid && i_ready
//   o_valid  out  drained word valid
//   o_ready  in   downstream accepts the drained word
//   o_data   out  drained word
//   o_last   out  final drained word
//   o_count  out  number of currently retained entries
module topk_fp32_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 8,
  parameter int DESCENDING = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_last,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_last,
  output logic [$clog2(K+1)-1:0]     o_count
);

  localparam int CW    = $clog2(K+1);
  localparam int KEY_W = DATA_WIDTH - 1;

  typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] slot [K];
  logic [CW-1:0]         count;
  logic [CW-1:0]         rd_idx;
  logic [CW-1:0]         rd_sel;
  logic [CW-1:0]         ins_pos;
  logic                  run;
  logic                  accept;
  logic                  last_beat;
  logic                  drain_hs;

  // Ordering key: everything below the sign bit.
  function automatic logic [KEY_W-1:0] key_of(input logic [DATA_WIDTH-1:0] w);
    return w[KEY_W-1:0];
  endfunction

  // Insert position = number of valid slots whose key is >= the new key.
  // Counting ">=" places a new word after existing equal keys.
  always_comb begin
    ins_pos = '0;
    for (int i = 0; i < K; i++) begin
      if ((CW'(i) < count) && (key_of(slot[i]) >= key_of(i_data)))
        ins_pos = ins_pos + CW'(1);
    end
  end

  assign accept    = i_valid && i_ready;
  assign last_beat = (state == DRAIN) && (rd_idx == count - CW'(1));
  assign drain_hs  = (state == DRAIN) && o_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= COLLECT;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept && i_last)    state_nxt = DRAIN;
      DRAIN:   if (drain_hs && last_beat) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // i_ready must stay low while reset is held, so it is gated by a flag
  // that only rises on the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  // Drain read index, mapped to a slot according to drain order.
  assign rd_sel = (DESCENDING != 0) ? rd_idx : (count - CW'(1) - rd_idx);

  // Output decode: state, slots and indices are all registers.
  always_comb begin
    i_ready = run && (state == COLLECT);
    o_valid = (state == DRAIN);
    o_last  = last_beat;
    o_count = count;
    o_data  = '0;
    if (state == DRAIN) begin
      for (int i = 0; i < K; i++) begin
        if (CW'(i) == rd_sel) o_data = slot[i];
      end
    end
  end

  // Sorted bank, count and drain index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < K; i++) slot[i] <= '0;
      count  <= '0;
      rd_idx <= '0;
    end else begin
      // ins_pos == K means the bank is full and the new word ranks last.
      if (accept && (ins_pos < CW'(K))) begin
        if (ins_pos == '0) slot[0] <= i_data;
        for (int i = 1; i < K; i++) begin
          if (CW'(i) == ins_pos)     slot[i] <= i_data;
          else if (CW'(i) > ins_pos) slot[i] <= slot[i-1];
        end
        if (count < CW'(K)) count <= count + CW'(1);
      end
      if (drain_hs) begin
        if (last_beat) begin
          count  <= '0;
          rd_idx <= '0;
        end else begin
          rd_idx <= rd_idx + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_topk_fp32_collector.sv
// Bench for topk_fp32_collector: two K=4 instances driven by the same stream,
// one draining largest-first and one smallest-first.
module tb_topk_fp32_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_last;
  logic        o_ready;

  logic        i_ready_d, o_valid_d, o_last_d;
  logic [31:0] o_data_d;
  logic [2:0]  o_count_d;
  logic        i_ready_a, o_valid_a, o_last_a;
  logic [31:0] o_data_a;
  logic [2:0]  o_count_a;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  topk_fp32_collector #(.DATA_WIDTH(32), .K(4), .DESCENDING(1)) dut (
    .clk(clk), .rst(rst_n),
    .i_valid(i_valid), .i_ready(i_ready_d), .i_data(i_data), .i_last(i_last),
    .o_valid(o_valid_d), .o_ready(o_ready), .o_data(o_data_d), .o_last(o_last_d),
    .o_count(o_count_d)
  );

  topk_fp32_collector #(.DATA_WIDTH(32), .K(4), .DESCENDING(0)) dut_asc (
    .clk(clk), .rst(rst_n),
    .i_valid(i_valid), .i_ready(i_ready_a), .i_data(i_data), .i_last(i_last),
    .o_valid(o_valid_a), .o_ready(o_ready), .o_data(o_data_a), .o_last(o_last_a),
    .o_count(o_count_a)
  );

  typedef struct packed {
    logic [7:0][31:0] din;   // stream words, last one carries i_last
    logic [3:0]       n_in;
    logic [3:0][31:0] dexp;  // expected largest-first drain
    logic [2:0]       n_out;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_stream(input vec_t v);
    for (int i = 0; i < int'(v.n_in); i++) begin
      int guard = 0;
      i_valid = 1'b1;
      i_data  = v.din[i];
      i_last  = (i == int'(v.n_in) - 1);
      while (!i_ready_d && guard < 20) begin
        tick();
        guard++;
      end
      chk("in_ready_wait", {31'd0, i_ready_d}, 32'd1);
      if (i_last) chk("ovalid_before_last", {31'd0, o_valid_d}, 32'd0);
      tick();
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    // Drain begins one cycle after the last accept.
    chk("ovalid_latency", {31'd0, o_valid_d}, 32'd1);
    chk("count_full",     {29'd0, o_count_d}, {29'd0, v.n_out});
  endtask

  task automatic drain_check(input vec_t v);
    o_ready = 1'b1;
    for (int j = 0; j < int'(v.n_out); j++) begin
      int guard = 0;
      while (!o_valid_d && guard < 20) begin
        tick();
        guard++;
      end
      chk("drain_valid",     {31'd0, o_valid_d}, 32'd1);
      chk("drain_data_desc", o_data_d, v.dexp[j]);
      chk("drain_data_asc",  o_data_a, v.dexp[int'(v.n_out) - 1 - j]);
      chk("drain_last",      {31'd0, o_last_d}, {31'd0, (j == int'(v.n_out) - 1)});
      chk("drain_iready",    {31'd0, i_ready_d}, 32'd0);
      tick();
    end
    o_ready = 1'b0;
    chk("post_ovalid", {31'd0, o_valid_d}, 32'd0);
    chk("post_iready", {31'd0, i_ready_d}, 32'd1);
    chk("post_count",  {29'd0, o_count_d}, 32'd0);
  endtask

  initial begin
    // Basic top-4 with one dropped word.
    vecs[0] = '0;
    vecs[0].din[0] = 32'h3F800000; vecs[0].din[1] = 32'h40400000;
    vecs[0].din[2] = 32'h40000000; vecs[0].din[3] = 32'h3F000000;
    vecs[0].din[4] = 32'h40800000; vecs[0].n_in = 4'd5;
    vecs[0].dexp[0] = 32'h40800000; vecs[0].dexp[1] = 32'h40400000;
    vecs[0].dexp[2] = 32'h40000000; vecs[0].dexp[3] = 32'h3F800000;
    vecs[0].n_out = 3'd4;
    // Sign ignored, equal keys keep arrival order.
    vecs[1] = '0;
    vecs[1].din[0] = 32'hC0A00000; vecs[1].din[1] = 32'h40000000;
    vecs[1].din[2] = 32'hC0000000; vecs[1].n_in = 4'd3;
    vecs[1].dexp[0] = 32'hC0A00000; vecs[1].dexp[1] = 32'h40000000;
    vecs[1].dexp[2] = 32'hC0000000; vecs[1].n_out = 3'd3;
    // Single word.
    vecs[2] = '0;
    vecs[2].din[0] = 32'h3F800000; vecs[2].n_in = 4'd1;
    vecs[2].dexp[0] = 32'h3F800000; vecs[2].n_out = 3'd1;
    // NaN above Inf, +0 and -0 equal (stable).
    vecs[3] = '0;
    vecs[3].din[0] = 32'h7F800000; vecs[3].din[1] = 32'h7FC00000;
    vecs[3].din[2] = 32'h00000000; vecs[3].din[3] = 32'h80000000;
    vecs[3].n_in = 4'd4;
    vecs[3].dexp[0] = 32'h7FC00000; vecs[3].dexp[1] = 32'h7F800000;
    vecs[3].dexp[2] = 32'h00000000; vecs[3].dexp[3] = 32'h80000000;
    vecs[3].n_out = 3'd4;
    // Full bank: a new word tying the smallest key is discarded.
    vecs[4] = '0;
    vecs[4].din[0] = 32'h3F800000; vecs[4].din[1] = 32'h3F800001;
    vecs[4].din[2] = 32'h3F800002; vecs[4].din[3] = 32'h3F800003;
    vecs[4].din[4] = 32'hBF800000; vecs[4].n_in = 4'd5;
    vecs[4].dexp[0] = 32'h3F800003; vecs[4].dexp[1] = 32'h3F800002;
    vecs[4].dexp[2] = 32'h3F800001; vecs[4].dexp[3] = 32'h3F800000;
    vecs[4].n_out = 3'd4;

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    o_ready = 1'b0;
    #3;
    chk("rst_ovalid", {31'd0, o_valid_d}, 32'd0);
    chk("rst_iready", {31'd0, i_ready_d}, 32'd0);
    chk("rst_odata",  o_data_d, 32'd0);
    chk("rst_olast",  {31'd0, o_last_d}, 32'd0);
    chk("rst_count",  {29'd0, o_count_d}, 32'd0);
    repeat (3) tick();
    chk("rst_held_iready", {31'd0, i_ready_d}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      send_stream(vecs[v]);
      drain_check(vecs[v]);
      tick();
    end

    // Backpressure mid-drain; input during DRAIN is ignored.
    send_stream(vecs[1]);
    o_ready = 1'b1;
    chk("bp_first", o_data_d, 32'hC0A00000);
    tick();
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h7F000000;
    i_last  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_data",   o_data_d, 32'h40000000);
      chk("bp_hold_valid",  {31'd0, o_valid_d}, 32'd1);
      chk("bp_hold_iready", {31'd0, i_ready_d}, 32'd0);
      chk("bp_hold_last",   {31'd0, o_last_d}, 32'd0);
      tick();
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    o_ready = 1'b1;
    chk("bp_second", o_data_d, 32'h40000000);
    tick();
    chk("bp_third",      o_data_d, 32'hC0000000);
    chk("bp_third_last", {31'd0, o_last_d}, 32'd1);
    tick();
    o_ready = 1'b0;
    chk("bp_done_valid", {31'd0, o_valid_d}, 32'd0);
    chk("bp_done_count", {29'd0, o_count_d}, 32'd0);
    tick();

    // Reset asserted after two drained beats.
    send_stream(vecs[0]);
    o_ready = 1'b1;
    tick();
    tick();
    chk("mid_third_word", o_data_d, 32'h40000000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  {31'd0, o_valid_d}, 32'd0);
    chk("mid_rst_count",  {29'd0, o_count_d}, 32'd0);
    chk("mid_rst_iready", {31'd0, i_ready_d}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("after_rst_valid", {31'd0, o_valid_d}, 32'd0);
    o_ready = 1'b0;
    vecs[2].din[0]  = 32'h40000000;
    vecs[2].dexp[0] = 32'h40000000;
    send_stream(vecs[2]);
    drain_check(vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
